msdf_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one serial-serial MSDF online adder between two digit-stream requesters. It grants the adder to one requester at a time and clears the adder pipeline before each operation. It then feeds N operand digit pairs followed by DELTA zero flush digits, collects N result digits and returns them to the owner with a done pulse. It sits between the requester blocks and the adder top level.

---
 rtl/msdf_pkg.sv | 17 +
 rtl/rr_arb2.sv | 36 +++
 rtl/msdf_add_arbiter.sv | 161 ++++++++++++++++
 tb/tb_msdf_add_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/msdf_pkg.sv
// Shared types for the MSDF adder arbiter: signed-digit encoding and sequencer states.
package msdf_pkg;

  typedef logic [1:0] digit_t;

  localparam digit_t DIGIT_ZERO = 2'b00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the requester not served last wins a contention.
module rr_arb2
  import msdf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last;

  // winner selection from current requests and last-served index
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // last-served index, moved when a grant is taken
  always_ff @(posedge clk) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      last <= grant[1];
    end else begin
      last <= last;
    end
  end

endmodule

// File: rtl/msdf_add_arbiter.sv
// Shares one serial MSDF online adder between two requesters: grant, clear,
// feed N digit pairs, flush DELTA zeros, collect N result digits, pulse done.
module msdf_add_arbiter
  import msdf_pkg::*;
#(
  parameter int N     = 9,
  parameter int DELTA = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] x0,
  input  logic [1:0] y0,
  input  logic [1:0] x1,
  input  logic [1:0] y1,
  output logic [1:0] dig_rdy,
  output logic [1:0] gnt,
  output logic       add_clr_n,
  output logic [1:0] add_x,
  output logic [1:0] add_y,
  input  logic [1:0] add_z,
  input  logic       add_zvalid,
  output logic [1:0] z_out,
  output logic       z_valid,
  output logic [1:0] done,
  output logic       err
);

  localparam int CW = $clog2(N + DELTA + 5);
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(DELTA - 1);
  localparam logic [CW-1:0] WD_LAST    = CW'(N + DELTA + 3);
  localparam logic [CW-1:0] ZN         = CW'(N);
  localparam logic [CW-1:0] ZN_M1      = CW'(N - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] zcnt;
  logic [1:0]    win;
  logic [1:0]    gnt_nx;
  logic          arb_take;
  logic          cap;
  logic          zfull_nx;
  logic          wd_exp;
  logic          busy;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (arb_take),
    .grant  (win)
  );

  // next state, result capture qualification and watchdog expiry
  always_comb begin
    busy     = (state == FEED) || (state == FLUSH) || (state == DRAIN);
    cap      = add_zvalid && busy && (zcnt < ZN);
    zfull_nx = (zcnt == ZN) || (cap && (zcnt == ZN_M1));
    wd_exp   = 1'b0;
    state_nx = state;
    case (state)
      IDLE:  state_nx = (req != 2'b00) ? START : IDLE;
      START: state_nx = FEED;
      FEED:  state_nx = (cnt == FEED_LAST) ? FLUSH : FEED;
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_nx = zfull_nx ? DONE : DRAIN;
        end else begin
          state_nx = FLUSH;
        end
      end
      DRAIN: begin
        if (zfull_nx) begin
          state_nx = DONE;
        end else if (cnt == WD_LAST) begin
          wd_exp   = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = DRAIN;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    arb_take = (state == IDLE) && (state_nx == START);
  end

  // owner for the coming cycle; fixed from START through DONE
  always_comb begin
    if (arb_take) begin
      gnt_nx = win;
    end else if (state_nx == IDLE) begin
      gnt_nx = 2'b00;
    end else begin
      gnt_nx = gnt;
    end
  end

  // operand digits reach the adder only while the owner is being fed
  always_comb begin
    if (dig_rdy[0]) begin
      add_x = x0;
      add_y = y0;
    end else if (dig_rdy[1]) begin
      add_x = x1;
      add_y = y1;
    end else begin
      add_x = DIGIT_ZERO;
      add_y = DIGIT_ZERO;
    end
  end

  // sequencer state, counters and registered outputs (decoded from next state)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      zcnt      <= '0;
      gnt       <= 2'b00;
      dig_rdy   <= 2'b00;
      add_clr_n <= 1'b1;
      z_out     <= DIGIT_ZERO;
      z_valid   <= 1'b0;
      done      <= 2'b00;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      dig_rdy   <= (state_nx == FEED) ? gnt_nx : 2'b00;
      add_clr_n <= (state_nx != START);
      done      <= (state_nx == DONE) ? gnt_nx : 2'b00;
      z_valid   <= cap;
      z_out     <= cap ? add_z : z_out;
      if (state_nx != state) begin
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt + ONE;
      end else begin
        cnt <= cnt;
      end
      if (state_nx == START) begin
        zcnt <= '0;
      end else if (cap) begin
        zcnt <= zcnt + ONE;
      end else begin
        zcnt <= zcnt;
      end
      if (state_nx == START) begin
        err <= 1'b0;
      end else if (wd_exp) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

endmodule

// File: tb/tb_msdf_add_arbiter.sv
// Directed bench for msdf_add_arbiter with a configurable online-adder stub.
module tb_msdf_add_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] x0, y0, x1, y1;
  logic [1:0] dig_rdy, gnt, add_x, add_y, add_z, z_out, done;
  logic       add_clr_n, add_zvalid, z_valid, err;

  int checks = 0;
  int errors = 0;
  int limit  = 9;

  logic [7:0] tcnt = 8'd0;
  logic [2:0] sh;
  logic [3:0] emitted;

  always #5 clk = ~clk;

  msdf_add_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .dig_rdy(dig_rdy), .gnt(gnt), .add_clr_n(add_clr_n),
    .add_x(add_x), .add_y(add_y), .add_z(add_z), .add_zvalid(add_zvalid),
    .z_out(z_out), .z_valid(z_valid), .done(done), .err(err)
  );

  // free-running operand pattern
  always @(posedge clk) tcnt <= tcnt + 8'd1;
  assign x0 = tcnt[1:0];
  assign y0 = ~tcnt[1:0];
  assign x1 = tcnt[2:1];
  assign y1 = 2'b11 ^ tcnt[2:1];

  // adder stub: result valid DELTA=3 cycles after each fed digit, capped at limit;
  // once 9 results are out it keeps emitting until limit (extra-valid case)
  always @(posedge clk) begin
    if (!rst || !add_clr_n) begin
      sh      <= 3'b000;
      emitted <= 4'd0;
    end else begin
      sh <= {sh[1:0], |dig_rdy};
      if (add_zvalid) emitted <= emitted + 4'd1;
    end
  end
  assign add_zvalid = (int'(emitted) < limit) && (sh[2] || (emitted >= 4'd9));
  assign add_z      = emitted[1:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_dig_rdy", dig_rdy, 2'b00);
    chk("rst_add_clr_n", add_clr_n, 1'b1);
    chk("rst_add_x", add_x, 2'b00);
    chk("rst_add_y", add_y, 2'b00);
    chk("rst_z_out", z_out, 2'b00);
    chk("rst_z_valid", z_valid, 1'b0);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 1'b0);
  endtask

  // Entered in an IDLE cycle (cycle 0). Checks every cycle up to DONE and one after.
  task automatic run_op(input logic [1:0] r, input logic [1:0] own, input int done_cyc,
                        input int nval, input logic err_exp, input int drop_k,
                        input logic [1:0] r_drop, input logic [1:0] r_end);
    int zc;
    logic [1:0] ex, ey;
    zc  = 0;
    req = r;
    for (int k = 1; k <= done_cyc; k++) begin
      tick();
      if (k == drop_k) req = r_drop;
      ex = 2'b00;
      ey = 2'b00;
      if (k >= 2 && k <= 10) begin
        ex = own[0] ? x0 : x1;
        ey = own[0] ? y0 : y1;
      end
      chk("gnt", gnt, own);
      chk("dig_rdy", dig_rdy, (k >= 2 && k <= 10) ? own : 2'b00);
      chk("add_clr_n", add_clr_n, (k == 1) ? 1'b0 : 1'b1);
      chk("add_x", add_x, ex);
      chk("add_y", add_y, ey);
      chk("z_valid", z_valid, (k >= 6 && k < 6 + nval) ? 1'b1 : 1'b0);
      if (z_valid) begin
        chk("z_out", z_out, zc[1:0]);
        zc++;
      end
      chk("done", done, (k == done_cyc) ? own : 2'b00);
      chk("err", err, (k == done_cyc) ? err_exp : 1'b0);
    end
    chk("z_count", zc, nval);
    req = r_end;
    tick();
    chk("idle_gnt", gnt, 2'b00);
    chk("idle_done", done, 2'b00);
    chk("idle_z_valid", z_valid, 1'b0);
    chk("idle_err", err, err_exp);
  endtask

  initial begin
    int waited;
    rst = 1'b0;
    req = 2'b00;
    tick();
    tick();
    check_reset_vals();
    rst = 1'b1;

    // single request, nominal adder
    run_op(2'b01, 2'b01, 14, 9, 1'b0, 0, 2'b00, 2'b00);

    // contention from reset: 01, 10, 01
    rst = 1'b0;
    tick();
    rst = 1'b1;
    run_op(2'b11, 2'b01, 14, 9, 1'b0, 0, 2'b11, 2'b11);
    run_op(2'b11, 2'b10, 14, 9, 1'b0, 0, 2'b11, 2'b11);
    run_op(2'b11, 2'b01, 14, 9, 1'b0, 0, 2'b11, 2'b00);

    // short stream: DRAIN entered at 14, watchdog DONE at 14+16
    limit = 7;
    run_op(2'b01, 2'b01, 30, 7, 1'b1, 0, 2'b00, 2'b00);

    // extra valids ignored, requester 1 alone
    limit = 11;
    run_op(2'b10, 2'b10, 14, 9, 1'b0, 0, 2'b00, 2'b00);

    // request dropped during FEED
    limit = 9;
    run_op(2'b01, 2'b01, 14, 9, 1'b0, 5, 2'b00, 2'b00);

    // reset during FLUSH
    req = 2'b01;
    for (int k = 1; k <= 12; k++) tick();
    chk("pre_rst_gnt", gnt, 2'b01);
    rst = 1'b0;
    req = 2'b00;
    tick();
    check_reset_vals();
    rst = 1'b1;
    req = 2'b01;
    tick();
    chk("restart_clr_n", add_clr_n, 1'b0);
    chk("restart_gnt", gnt, 2'b01);
    waited = 0;
    while (done == 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
    chk("restart_done", done, 2'b01);
    chk("restart_latency", waited, 13);
    req = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
